wbu_commit: RTL and testbench
=============================

Name: wbu_commit

Overview:
- Write-back/commit stage of the multi-cycle NPC. Sits between the LSU/EXU result path and the architectural state: GPR file, CSR file and the IFU next-PC.
- Takes one finished instruction per handshake and issues its GPR and CSR side effects exactly once.
- Drives the CSR file's WBU-side controls (valid, write, ecall, mret, pc).
- Then hands the resolved next PC to the IFU over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, datapath, PC and CSR data width.
- CSR_ADDR_WIDTH, 12, CSR address width.
- REG_ADDR_WIDTH, 5, GPR index width (4 for RV32E builds).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_pc  in  DATA_WIDTH  PC of the instruction.
- in_dnpc  in  DATA_WIDTH  resolved next PC (mtvec/mepc already selected upstream for ecall/mret).
- in_rd  in  REG_ADDR_WIDTH  destination GPR.
- in_rd_wen  in  1  GPR write request.
- in_rd_data  in  DATA_WIDTH  GPR write data.
- in_csr_wen  in  1  csrrw/csrrs/csrrc write request.
- in_csr_addr  in  CSR_ADDR_WIDTH  CSR write address.
- in_csr_wdata  in  DATA_WIDTH  CSR write data.
- in_is_ecall  in  1  instruction is ecall.
- in_is_mret  in  1  instruction is mret.
- in_is_ebreak  in  1  instruction is ebreak (simulation halt).
- rf_wen  out  1  GPR write strobe.
- rf_waddr  out  REG_ADDR_WIDTH  GPR write address.
- rf_wdata  out  DATA_WIDTH  GPR write data.
- valid_wbu  out  1  CSR file commit strobe.
- csr_wen  out  1  CSR write enable.
- csr_waddr  out  CSR_ADDR_WIDTH  CSR address.
- csr_wdata  out  DATA_WIDTH  CSR data.
- is_ecall_wbu  out  1  ecall commit.
- is_mret_wbu  out  1  mret commit.
- csr_pc  out  DATA_WIDTH  PC for mepc capture.
- out_valid  out  1  next PC valid to IFU.
- out_ready  in  1  IFU accepts next PC.
- out_dnpc  out  DATA_WIDTH  next PC.
- halt  out  1  sticky ebreak halt.
- perf_retired  out  64  retired-instruction count.
- perf_ecalls  out  32  ecall count.

Behaviour:
- The reset statement is fixed: one clock, clk; reset rst is asynchronous, active-high. On reset, state=IDLE, all payload registers=0, all outputs=0 except in_ready=1.
- FSM states: IDLE, WRITE, NOTIFY, HALT.
- IDLE:
  - in_ready=1.
  - in_valid=1 latches all in_* into payload registers and moves to WRITE.
- WRITE, exactly one cycle (side-effect cycle):
  - valid_wbu=1.
  - rf_wen = rd_wen and (rd!=0).
  - csr_wen = csr_wen_q and not ecall_q.
  - is_ecall_wbu = ecall_q.
  - is_mret_wbu = mret_q and not ecall_q.
  - out_valid=1.
  - If ebreak_q, go to HALT; no out_valid in this cycle.
  - Else if out_ready=1, go to IDLE.
  - Else go to NOTIFY.
- NOTIFY:
  - All write strobes are 0; side effects are never repeated.
  - out_valid=1 with a stable out_dnpc until out_ready, then go to IDLE.
- HALT:
  - halt=1 and in_ready=0.
  - Left only by reset.
- Latency: accept in cycle N → writes in N+1 → earliest next accept in N+2. Throughput is at most 1 instruction per 2 cycles.
- Address and data outputs are driven from payload registers in all states. Only the strobes gate them.
- Boundary rules:
  - rd=0 never writes.
  - ecall+mret together: ecall wins.
  - ecall+csr_wen together: CSR write dropped.
  - ebreak still commits its GPR/CSR strobes in WRITE.
  - in_valid outside IDLE is ignored, and upstream must hold it.
  - Reset asserted in WRITE or NOTIFY drops the instruction with no strobes after reset assertion.
  - Payload registers update only on the accept handshake.

Optional Feature:
- Macro WBU_PERF_EN.
- Defined:
  - perf_retired increments by 1 on each WRITE cycle, including ebreak.
  - perf_ecalls increments on each WRITE with ecall_q.
  - Both counters wrap modulo 2^width and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package/header npc_defs holds:
  - WBU state encodings: IDLE=2'd0, WRITE=2'd1, NOTIFY=2'd2, HALT=2'd3.
  - CSR address constants: 0x300, 0x305, 0x341, 0x342, 0xF11, 0xF12.
  - MCAUSE_ECALL_M = 32'hb.
- One sub-module, wbu_perf_cnt, holds both counters and is instantiated only under WBU_PERF_EN.

Test Plan:
- addi commit:
  - Stimulus: in_valid with rd=5, rd_wen=1, rd_data=0x1234, dnpc=0x80000004, out_ready=1.
  - Response: next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, valid_wbu=1, out_valid=1, out_dnpc=0x80000004; IDLE the cycle after.
- rd=0:
  - Stimulus: rd=0, rd_wen=1, rd_data=0xFFFF.
  - Response: rf_wen stays 0 throughout; out_valid still pulses.
- ecall:
  - Stimulus: ecall with csr_wen=1, csr_addr=0x305, pc=0x80000010, dnpc=0x80001000.
  - Response: is_ecall_wbu=1, csr_wen=0, csr_pc=0x80000010, out_dnpc=0x80001000.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after accept, csr write to 0x341 data 0xABCD.
  - Response: csr_wen=1 for exactly 1 cycle; out_valid=1 for 4 cycles; in_ready=0 until the cycle after out_ready=1.
- ebreak, then async reset:
  - Stimulus: ebreak, then assert rst mid-cycle while in HALT.
  - Response: halt=1 sticky, new in_valid ignored; rst immediately clears halt and sets in_ready=1.
- WBU_PERF_EN:
  - Stimulus: 10 commits including 2 ecalls.
  - Response: perf_retired=10, perf_ecalls=2. Without the macro, both read 0.

Source files
------------

// File: rtl/npc_defs.sv
// Shared NPC definitions: write-back FSM encodings, machine CSR addresses, trap causes.
package npc_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        NOTIFY = 2'd2,
        HALT   = 2'd3
    } wbu_state_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'hb;

endpackage

// File: rtl/wbu_perf_cnt.sv
// Retired-instruction and ecall counters for the write-back stage; update one cycle after the strobe.
// No backpressure: counts every strobe and wraps silently.
module wbu_perf_cnt #(
    parameter int RET_W   = 64,
    parameter int ECALL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               retire_i,
    input  logic               ecall_i,
    output logic [RET_W-1:0]   retired_o,
    output logic [ECALL_W-1:0] ecalls_o
);

    logic [RET_W-1:0]   retired_q;
    logic [ECALL_W-1:0] ecalls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            ecalls_q  <= '0;
        end else begin
            if (retire_i) retired_q <= retired_q + 1'b1;
            if (ecall_i)  ecalls_q  <= ecalls_q + 1'b1;
        end
    end

    assign retired_o = retired_q;
    assign ecalls_o  = ecalls_q;

endmodule

// File: rtl/wbu_commit.sv
// Commit stage: accept in N, GPR/CSR strobes once in N+1, next PC to IFU held until out_ready; 1 instr / 2 cycles max.
// ebreak parks the stage in HALT until reset. WBU_PERF_EN builds the retire/ecall counters.
module wbu_commit
    import npc_defs::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_dnpc,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_rd_wen,
    input  logic [DATA_WIDTH-1:0]     in_rd_data,
    input  logic                      in_csr_wen,
    input  logic [CSR_ADDR_WIDTH-1:0] in_csr_addr,
    input  logic [DATA_WIDTH-1:0]     in_csr_wdata,
    input  logic                      in_is_ecall,
    input  logic                      in_is_mret,
    input  logic                      in_is_ebreak,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      valid_wbu,
    output logic                      csr_wen,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr,
    output logic [DATA_WIDTH-1:0]     csr_wdata,
    output logic                      is_ecall_wbu,
    output logic                      is_mret_wbu,
    output logic [DATA_WIDTH-1:0]     csr_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_dnpc,
    output logic                      halt,
    output logic [63:0]               perf_retired,
    output logic [31:0]               perf_ecalls
);

    wbu_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]     pc_q, dnpc_q, rd_data_q, csr_wdata_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [CSR_ADDR_WIDTH-1:0] csr_addr_q;
    logic                      rd_wen_q, csr_wen_q, ecall_q, mret_q, ebreak_q;
    logic                      accept;

    assign accept = (state_q == IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            dnpc_q      <= '0;
            rd_q        <= '0;
            rd_wen_q    <= 1'b0;
            rd_data_q   <= '0;
            csr_wen_q   <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
            ecall_q     <= 1'b0;
            mret_q      <= 1'b0;
            ebreak_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q        <= in_pc;
                dnpc_q      <= in_dnpc;
                rd_q        <= in_rd;
                rd_wen_q    <= in_rd_wen;
                rd_data_q   <= in_rd_data;
                csr_wen_q   <= in_csr_wen;
                csr_addr_q  <= in_csr_addr;
                csr_wdata_q <= in_csr_wdata;
                ecall_q     <= in_is_ecall;
                mret_q      <= in_is_mret;
                ebreak_q    <= in_is_ebreak;
            end
        end
    end

    // Strobes exist only in WRITE, so stalling in NOTIFY can never replay a side effect.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        valid_wbu    = 1'b0;
        rf_wen       = 1'b0;
        csr_wen      = 1'b0;
        is_ecall_wbu = 1'b0;
        is_mret_wbu  = 1'b0;
        out_valid    = 1'b0;
        halt         = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = WRITE;
            end
            WRITE: begin
                valid_wbu    = 1'b1;
                rf_wen       = rd_wen_q && (rd_q != '0);
                csr_wen      = csr_wen_q && !ecall_q;
                is_ecall_wbu = ecall_q;
                is_mret_wbu  = mret_q && !ecall_q;
                if (ebreak_q) begin
                    state_d = HALT;
                end else begin
                    out_valid = 1'b1;
                    state_d   = out_ready ? IDLE : NOTIFY;
                end
            end
            NOTIFY: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            HALT: begin
                halt = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rf_waddr  = rd_q;
    assign rf_wdata  = rd_data_q;
    assign csr_waddr = csr_addr_q;
    assign csr_wdata = csr_wdata_q;
    assign csr_pc    = pc_q;
    assign out_dnpc  = dnpc_q;

`ifdef WBU_PERF_EN
    logic retire;
    assign retire = (state_q == WRITE);

    wbu_perf_cnt #(
        .RET_W  (64),
        .ECALL_W(32)
    ) u_perf_cnt (
        .clk      (clk),
        .rst      (rst),
        .retire_i (retire),
        .ecall_i  (retire && ecall_q),
        .retired_o(perf_retired),
        .ecalls_o (perf_ecalls)
    );
`else
    assign perf_retired = '0;
    assign perf_ecalls  = '0;
`endif

endmodule

// File: tb/tb_wbu_commit.sv
// Directed bench for wbu_commit: vector table for single commits plus backpressure, halt and reset sequences.
module tb_wbu_commit;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_dnpc, in_rd_data, in_csr_wdata;
    logic [4:0]  in_rd;
    logic        in_rd_wen, in_csr_wen, in_is_ecall, in_is_mret, in_is_ebreak;
    logic [11:0] in_csr_addr;
    logic        rf_wen, valid_wbu, csr_wen, is_ecall_wbu, is_mret_wbu;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, csr_wdata, csr_pc, out_dnpc;
    logic [11:0] csr_waddr;
    logic        out_valid, out_ready, halt;
    logic [63:0] perf_retired;
    logic [31:0] perf_ecalls;

    int tests = 0;
    int fails = 0;

    wbu_commit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_dnpc(in_dnpc),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_rd_data(in_rd_data),
        .in_csr_wen(in_csr_wen), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
        .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret), .in_is_ebreak(in_is_ebreak),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .valid_wbu(valid_wbu), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .is_ecall_wbu(is_ecall_wbu), .is_mret_wbu(is_mret_wbu), .csr_pc(csr_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_dnpc(out_dnpc),
        .halt(halt), .perf_retired(perf_retired), .perf_ecalls(perf_ecalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] rd_data;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        ecall;
        logic        mret;
        logic [31:0] pc;
        logic [31:0] dnpc;
        logic        e_rf_wen;
        logic        e_csr_wen;
        logic        e_ecall;
        logic        e_mret;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_pc = 0; in_dnpc = 0; in_rd = 0; in_rd_wen = 0; in_rd_data = 0;
        in_csr_wen = 0; in_csr_addr = 0; in_csr_wdata = 0;
        in_is_ecall = 0; in_is_mret = 0; in_is_ebreak = 0;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1; in_rd = v.rd; in_rd_wen = v.rd_wen; in_rd_data = v.rd_data;
        in_csr_wen = v.csr_wen; in_csr_addr = v.csr_addr; in_csr_wdata = v.csr_wdata;
        in_is_ecall = v.ecall; in_is_mret = v.mret; in_is_ebreak = 0;
        in_pc = v.pc; in_dnpc = v.dnpc;
    endtask

    logic [63:0] exp_ret;
    logic [63:0] exp_ecl;
    int          n_csr, n_ov;

    initial begin
        // rd rw data csrw addr wdata ecall mret pc dnpc | rf csr ecall mret
        vecs[0] = '{5'd5, 1, 32'h1234, 0, 12'h000, 32'h0, 0, 0, 32'h80000000, 32'h80000004, 1, 0, 0, 0};
        vecs[1] = '{5'd0, 1, 32'hFFFF, 0, 12'h000, 32'h0, 0, 0, 32'h80000004, 32'h80000008, 0, 0, 0, 0};
        vecs[2] = '{5'd0, 0, 32'h0, 1, 12'h305, 32'h55, 1, 0, 32'h80000010, 32'h80001000, 0, 0, 1, 0};
        vecs[3] = '{5'd0, 0, 32'h0, 0, 12'h000, 32'h0, 0, 1, 32'h80001008, 32'h80000020, 0, 0, 0, 1};
        vecs[4] = '{5'd1, 1, 32'hDEAD, 0, 12'h342, 32'h0, 1, 1, 32'h80000030, 32'h80001000, 1, 0, 1, 0};
        vecs[5] = '{5'd10, 1, 32'h77, 1, 12'h300, 32'h1888, 0, 0, 32'h80000040, 32'h80000044, 1, 1, 0, 0};
        vecs[6] = '{5'd7, 0, 32'h99, 0, 12'h000, 32'h0, 0, 0, 32'h80000044, 32'h80000048, 0, 0, 0, 0};
        vecs[7] = '{5'd31, 1, 32'hCAFE, 1, 12'hF11, 32'h42, 0, 1, 32'h80000048, 32'h8000004C, 1, 1, 0, 1};

        clear_inputs();
        out_ready = 1;
        rst = 1;
        #3;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset valid_wbu", valid_wbu, 0);
        chk("reset halt", halt, 0);
        chk("reset out_dnpc", out_dnpc, 0);
        chk("reset rf_wdata", rf_wdata, 0);
        chk("reset perf_retired", perf_retired, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d idle in_ready", i), in_ready, 1);
            drive(vecs[i]);
            @(negedge clk);
            in_valid = 0;
            chk($sformatf("v%0d valid_wbu", i), valid_wbu, 1);
            chk($sformatf("v%0d in_ready", i), in_ready, 0);
            chk($sformatf("v%0d rf_wen", i), rf_wen, vecs[i].e_rf_wen);
            chk($sformatf("v%0d rf_waddr", i), rf_waddr, vecs[i].rd);
            chk($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].rd_data);
            chk($sformatf("v%0d csr_wen", i), csr_wen, vecs[i].e_csr_wen);
            chk($sformatf("v%0d csr_waddr", i), csr_waddr, vecs[i].csr_addr);
            chk($sformatf("v%0d csr_wdata", i), csr_wdata, vecs[i].csr_wdata);
            chk($sformatf("v%0d is_ecall", i), is_ecall_wbu, vecs[i].e_ecall);
            chk($sformatf("v%0d is_mret", i), is_mret_wbu, vecs[i].e_mret);
            chk($sformatf("v%0d csr_pc", i), csr_pc, vecs[i].pc);
            chk($sformatf("v%0d out_valid", i), out_valid, 1);
            chk($sformatf("v%0d out_dnpc", i), out_dnpc, vecs[i].dnpc);
            @(negedge clk);
            chk($sformatf("v%0d after in_ready", i), in_ready, 1);
            chk($sformatf("v%0d after out_valid", i), out_valid, 0);
            chk($sformatf("v%0d after rf_wen", i), rf_wen, 0);
            chk($sformatf("v%0d after valid_wbu", i), valid_wbu, 0);
        end

        // Backpressure: out_ready low for WRITE and two NOTIFY cycles, high in the third NOTIFY.
        @(negedge clk);
        clear_inputs();
        in_valid = 1; in_csr_wen = 1; in_csr_addr = 12'h341; in_csr_wdata = 32'hABCD;
        in_pc = 32'h80000050; in_dnpc = 32'h80000100;
        out_ready = 0;
        n_csr = 0; n_ov = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 0;
            if (csr_wen) n_csr++;
            if (out_valid) begin
                n_ov++;
                chk($sformatf("bp out_dnpc c%0d", c), out_dnpc, 32'h80000100);
            end
            chk($sformatf("bp in_ready c%0d", c), in_ready, (c == 5) ? 1 : 0);
            if (c == 4) out_ready = 1;
        end
        chk("bp csr_wen cycles", n_csr, 1);
        chk("bp out_valid cycles", n_ov, 4);

        // ebreak still commits its GPR write, then halts with no out_valid.
        @(negedge clk);
        clear_inputs();
        in_valid = 1; in_is_ebreak = 1; in_rd = 5'd3; in_rd_wen = 1; in_rd_data = 32'h77;
        in_dnpc = 32'h80000200;
        @(negedge clk);
        clear_inputs();
        chk("ebreak rf_wen", rf_wen, 1);
        chk("ebreak valid_wbu", valid_wbu, 1);
        chk("ebreak out_valid", out_valid, 0);
        chk("ebreak halt in WRITE", halt, 0);
        @(negedge clk);
        chk("halt set", halt, 1);
        chk("halt in_ready", in_ready, 0);
        in_valid = 1; in_rd = 5'd9; in_rd_wen = 1; in_rd_data = 32'h5555;
        @(negedge clk);
        @(negedge clk);
        chk("halt sticky", halt, 1);
        chk("halt ignores in_valid rf_wen", rf_wen, 0);
        chk("halt ignores in_valid valid_wbu", valid_wbu, 0);
        chk("halt payload unchanged", rf_waddr, 3);
        chk("halt out_valid", out_valid, 0);
`ifdef WBU_PERF_EN
        exp_ret = 64'd10;
        exp_ecl = 64'd2;
`else
        exp_ret = 64'd0;
        exp_ecl = 64'd0;
`endif
        chk("perf_retired", perf_retired, exp_ret);
        chk("perf_ecalls", perf_ecalls, exp_ecl);
        clear_inputs();
        #2 rst = 1;
        #1;
        chk("async rst halt", halt, 0);
        chk("async rst in_ready", in_ready, 1);
        chk("async rst rf_waddr", rf_waddr, 0);
        chk("async rst perf_retired", perf_retired, 0);
        chk("async rst perf_ecalls", perf_ecalls, 0);
        @(negedge clk);
        rst = 0;

        // Reset landing in WRITE drops every strobe at once.
        @(negedge clk);
        drive(vecs[5]);
        @(negedge clk);
        in_valid = 0;
        chk("pre-rst WRITE rf_wen", rf_wen, 1);
        #2 rst = 1;
        #1;
        chk("rst in WRITE rf_wen", rf_wen, 0);
        chk("rst in WRITE csr_wen", csr_wen, 0);
        chk("rst in WRITE valid_wbu", valid_wbu, 0);
        chk("rst in WRITE out_valid", out_valid, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post-rst idle no strobe", valid_wbu, 0);
        drive(vecs[0]);
        @(negedge clk);
        in_valid = 0;
        chk("post-rst commit rf_wen", rf_wen, 1);
        chk("post-rst commit out_dnpc", out_dnpc, 32'h80000004);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
